// File: rtl/lsu_tlbrd_retq.sv
`default_nettype none
// ============================================================================
// Module   : lsu_tlbrd_retq
// Purpose  : Per-strand holding slots for TLB diag reads, round-robin ldxa
//            return arbitration, sticky parity status and first-error log.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_tlbrd_retq #(
  parameter int NTHR = 4,
  parameter int DW   = 64
) (
  input  logic            rclk,
  input  logic            rst,
  input  logic            tlb_rd_vld_g,
  input  logic [1:0]      tlb_rd_tid_g,
  input  logic            tlb_rd_is_data_g,
  input  logic [DW-1:0]   lsu_tlb_rd_data,
  input  logic            tte_data_parity_error,
  input  logic            tte_tag_parity_error,
  input  logic            ret_ack,
  input  logic [NTHR-1:0] err_clr,
  output logic            ret_vld,
  output logic [1:0]      ret_tid,
  output logic [DW-1:0]   ret_data,
  output logic            ret_perr,
  output logic [NTHR-1:0] slot_busy,
  output logic            rd_ovf,
  output logic [NTHR-1:0] err_sticky,
  output logic            err_log_vld,
  output logic [1:0]      err_log_tid,
  output logic            err_log_type
);

  logic [NTHR-1:0] r_slot_vld;
  logic [DW-1:0]   r_slot_data [NTHR];
  logic [NTHR-1:0] r_slot_perr;
  logic            r_gnt_vld;
  logic [1:0]      r_gnt_tid;
  logic [1:0]      r_rr_ptr;
  logic            r_ovf;
  logic [NTHR-1:0] r_err_sticky;
  logic            r_log_vld;
  logic [1:0]      r_log_tid;
  logic            r_log_type;

  logic            w_ack;
  logic            w_tid_ok;
  logic            w_drain_same;
  logic            w_acc;
  logic            w_ovf;
  logic            w_perr_in;
  logic [NTHR-1:0] w_err_set;
  logic [1:0]      w_next_ptr;
  logic [NTHR-1:0] w_elig;
  logic [1:0]      w_base;
  logic            w_sel_vld;
  logic [1:0]      w_sel_tid;

  function automatic logic [1:0] f_wrap(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NTHR) s = s - NTHR;
    return s[1:0];
  endfunction

  assign w_ack        = ret_ack & r_gnt_vld;
  assign w_tid_ok     = int'(tlb_rd_tid_g) < NTHR;
  assign w_drain_same = w_ack & (r_gnt_tid == tlb_rd_tid_g);
  assign w_acc        = tlb_rd_vld_g & w_tid_ok & (~r_slot_vld[tlb_rd_tid_g] | w_drain_same);
  assign w_ovf        = tlb_rd_vld_g & w_tid_ok & r_slot_vld[tlb_rd_tid_g] & ~w_drain_same;
  assign w_perr_in    = tlb_rd_is_data_g ? tte_data_parity_error : tte_tag_parity_error;
  assign w_err_set    = (w_acc & w_perr_in) ? (NTHR'(1) << tlb_rd_tid_g) : '0;
  assign w_next_ptr   = (int'(r_gnt_tid) == NTHR - 1) ? 2'd0 : r_gnt_tid + 2'd1;

  // On ack the acked slot is excluded even if refilled this cycle.
  always_comb begin
    w_elig    = r_slot_vld;
    w_base    = r_rr_ptr;
    w_sel_vld = 1'b0;
    w_sel_tid = 2'd0;
    if (w_ack) begin
      w_elig = r_slot_vld & ~(NTHR'(1) << r_gnt_tid);
      w_base = w_next_ptr;
    end
    for (int i = NTHR - 1; i >= 0; i--) begin
      if (w_elig[f_wrap(w_base, i)]) begin
        w_sel_vld = 1'b1;
        w_sel_tid = f_wrap(w_base, i);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      r_slot_vld   <= '0;
      r_slot_perr  <= '0;
      for (int t = 0; t < NTHR; t++) r_slot_data[t] <= '0;
      r_gnt_vld    <= 1'b0;
      r_gnt_tid    <= 2'd0;
      r_rr_ptr     <= 2'd0;
      r_ovf        <= 1'b0;
      r_err_sticky <= '0;
      r_log_vld    <= 1'b0;
      r_log_tid    <= 2'd0;
      r_log_type   <= 1'b0;
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        if (w_acc && (tlb_rd_tid_g == 2'(t))) begin
          r_slot_vld[t]  <= 1'b1;
          r_slot_data[t] <= lsu_tlb_rd_data;
          r_slot_perr[t] <= w_perr_in;
        end else if (w_ack && (r_gnt_tid == 2'(t))) begin
          r_slot_vld[t]  <= 1'b0;
        end
      end
      r_ovf <= w_ovf;
      if (!r_gnt_vld || ret_ack) begin
        r_gnt_vld <= w_sel_vld;
        if (w_sel_vld) r_gnt_tid <= w_sel_tid;
      end
      if (w_ack) r_rr_ptr <= w_next_ptr;
      r_err_sticky <= (r_err_sticky & ~err_clr) | w_err_set;
      if (!r_log_vld) begin
        if (w_acc && w_perr_in) begin
          r_log_vld  <= 1'b1;
          r_log_tid  <= tlb_rd_tid_g;
          r_log_type <= tlb_rd_is_data_g;
        end
      end else if (r_err_sticky == '0) begin
        r_log_vld <= 1'b0;
      end
    end
  end

  assign ret_vld      = r_gnt_vld;
  assign ret_tid      = r_gnt_tid;
  assign ret_data     = r_slot_data[r_gnt_tid];
  assign ret_perr     = r_slot_perr[r_gnt_tid];
  assign slot_busy    = r_slot_vld;
  assign rd_ovf       = r_ovf;
  assign err_sticky   = r_err_sticky;
  assign err_log_vld  = r_log_vld;
  assign err_log_tid  = r_log_tid;
  assign err_log_type = r_log_type;

endmodule
`default_nettype wire

// File: tb/tb_lsu_tlbrd_retq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_tlbrd_retq
// Purpose  : Directed vector bench for lsu_tlbrd_retq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_tlbrd_retq;

  logic        rclk = 1'b0;
  logic        rst, vld, isd, dpe, tpe, ack;
  logic [1:0]  tid;
  logic [63:0] din;
  logic [3:0]  clr;
  logic        ret_vld, ret_perr, rd_ovf, err_log_vld, err_log_type;
  logic [1:0]  ret_tid, err_log_tid;
  logic [63:0] ret_data;
  logic [3:0]  slot_busy, err_sticky;

  int n_chk = 0;
  int n_err = 0;

  always #5 rclk = ~rclk;

  lsu_tlbrd_retq #(.NTHR(4), .DW(64)) dut (
    .rclk(rclk), .rst(rst), .tlb_rd_vld_g(vld), .tlb_rd_tid_g(tid),
    .tlb_rd_is_data_g(isd), .lsu_tlb_rd_data(din),
    .tte_data_parity_error(dpe), .tte_tag_parity_error(tpe),
    .ret_ack(ack), .err_clr(clr), .ret_vld(ret_vld), .ret_tid(ret_tid),
    .ret_data(ret_data), .ret_perr(ret_perr), .slot_busy(slot_busy),
    .rd_ovf(rd_ovf), .err_sticky(err_sticky), .err_log_vld(err_log_vld),
    .err_log_tid(err_log_tid), .err_log_type(err_log_type)
  );

  typedef struct {
    logic r, v; logic [1:0] t; logic d; logic [63:0] dat;
    logic dp, tp, a; logic [3:0] c;
    logic ev; logic [1:0] et; logic [63:0] ed; logic ep;
    logic [3:0] eb; logic eo; logic [3:0] es; logic elv; logic [1:0] elt; logic ely;
  } vec_t;

  function automatic vec_t mk(
    input logic r, v, input logic [1:0] t, input logic d, input logic [63:0] dat,
    input logic dp, tp, a, input logic [3:0] c,
    input logic ev, input logic [1:0] et, input logic [63:0] ed, input logic ep,
    input logic [3:0] eb, input logic eo, input logic [3:0] es,
    input logic elv, input logic [1:0] elt, input logic ely);
    vec_t x;
    x.r = r; x.v = v; x.t = t; x.d = d; x.dat = dat; x.dp = dp; x.tp = tp;
    x.a = a; x.c = c; x.ev = ev; x.et = et; x.ed = ed; x.ep = ep; x.eb = eb;
    x.eo = eo; x.es = es; x.elv = elv; x.elt = elt; x.ely = ely;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, input logic [1:0] t, input logic d,
                       input logic [63:0] dat, input logic dp, tp, a,
                       input logic [3:0] c);
    rst = r; vld = v; tid = t; isd = d; din = dat; dpe = dp; tpe = tp; ack = a; clr = c;
  endtask

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [16:0] ctrl_now;
    return {ret_vld, ret_tid, ret_perr, slot_busy, rd_ovf, err_sticky,
            err_log_vld, err_log_tid, err_log_type};
  endfunction

  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_1234;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'h3333;
  localparam logic [63:0] D4 = 64'h4444;

  vec_t tbl [17];

  initial begin
    //           r  v  t  d  dat     dp tp a  clr     ev et ed  ep eb       eo es       lv lt ly
    tbl[0]  = mk(1, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   0, 0, 0,  0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 2, 0, D1,     0, 0, 0, 4'h0,   0, 0, 0,  0, 4'b0100, 0, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   1, 2, D1, 0, 4'b0100, 0, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 64'h0,  0, 0, 1, 4'h0,   0, 0, 0,  0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, D2,     0, 0, 0, 4'h0,   0, 0, 0,  0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   1, 1, D2, 0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 64'hBAD0, 1, 0, 0, 4'h0, 1, 1, D2, 0, 4'b0010, 1, 4'b0000, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   1, 1, D2, 0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 64'h0,  0, 0, 1, 4'h0,   0, 0, 0,  0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[9]  = mk(0, 1, 3, 1, D3,     1, 0, 0, 4'h0,   0, 0, 0,  0, 4'b1000, 0, 4'b1000, 1, 3, 1);
    tbl[10] = mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   1, 3, D3, 1, 4'b1000, 0, 4'b1000, 1, 3, 1);
    tbl[11] = mk(0, 0, 0, 0, 64'h0,  0, 0, 1, 4'h0,   0, 0, 0,  0, 4'b0000, 0, 4'b1000, 1, 3, 1);
    tbl[12] = mk(0, 1, 0, 0, D4,     0, 1, 0, 4'h0,   0, 0, 0,  0, 4'b0001, 0, 4'b1001, 1, 3, 1);
    tbl[13] = mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   1, 0, D4, 1, 4'b0001, 0, 4'b1001, 1, 3, 1);
    tbl[14] = mk(0, 0, 0, 0, 64'h0,  0, 0, 1, 4'b1001, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 3, 1);
    tbl[15] = mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 4'h0,   0, 0, 0,  0, 4'b0000, 0, 4'b0000, 0, 3, 1);
    tbl[16] = mk(0, 0, 0, 0, 64'h0,  0, 0, 1, 4'h0,   0, 0, 0,  0, 4'b0000, 0, 4'b0000, 0, 3, 1);

    for (int i = 0; i < 17; i++) begin
      logic [16:0] exp, msk;
      drive(tbl[i].r, tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].dat,
            tbl[i].dp, tbl[i].tp, tbl[i].a, tbl[i].c);
      tick();
      exp = {tbl[i].ev, tbl[i].et, tbl[i].ep, tbl[i].eb, tbl[i].eo, tbl[i].es,
             tbl[i].elv, tbl[i].elt, tbl[i].ely};
      // Idle-bus tid/perr/data are don't-care except straight out of reset.
      msk = (tbl[i].ev || tbl[i].r) ? 17'h1FFFF : 17'h11FFF;
      chk($sformatf("vec%0d_ctrl", i), 64'(ctrl_now() & msk), 64'(exp & msk));
      if (tbl[i].ev || tbl[i].r) chk($sformatf("vec%0d_data", i), ret_data, tbl[i].ed);
    end

    // Four reads, stalled return, then back-to-back drain 0,1,2,3.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 2'(k), 0, 64'hA0 + 64'(k), 0, 0, 0, 4'h0);
      tick();
    end
    drive(0, 0, 0, 0, 64'h0, 0, 0, 0, 4'h0);
    chk("rr_busy_all", 64'(slot_busy), 64'hF);
    for (int k = 0; k < 5; k++) begin
      chk("rr_stall_tid", 64'({ret_vld, ret_tid}), 64'({1'b1, 2'd0}));
      chk("rr_stall_data", ret_data, 64'hA0);
      tick();
    end
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_drain%0d_tid", k), 64'({ret_vld, ret_tid}), 64'({1'b1, 2'(k)}));
      chk($sformatf("rr_drain%0d_data", k), ret_data, 64'hA0 + 64'(k));
      tick();
    end
    ack = 1'b0;
    chk("rr_empty", 64'({ret_vld, slot_busy}), 64'h0);

    // Simultaneous drain and refill of slot 1.
    drive(0, 1, 1, 0, 64'hAAAA, 0, 0, 0, 4'h0); tick();
    drive(0, 1, 2, 0, 64'h2222, 0, 0, 0, 4'h0); tick();
    chk("refill_gnt1", 64'({ret_vld, ret_tid}), 64'({1'b1, 2'd1}));
    chk("refill_data1", ret_data, 64'hAAAA);
    drive(0, 1, 1, 0, 64'h5555, 0, 0, 1, 4'h0); tick();
    chk("refill_busy", 64'(slot_busy), 64'b0110);
    chk("refill_gnt2", 64'({ret_vld, ret_tid}), 64'({1'b1, 2'd2}));
    chk("refill_data2", ret_data, 64'h2222);
    drive(0, 0, 0, 0, 64'h0, 0, 0, 1, 4'h0); tick();
    chk("refill_gnt1b", 64'({ret_vld, ret_tid, slot_busy}), 64'({1'b1, 2'd1, 4'b0010}));
    chk("refill_data1b", ret_data, 64'h5555);
    tick();
    chk("refill_done", 64'({ret_vld, slot_busy}), 64'h0);

    // Reset mid-handshake with three full slots and a logged error.
    drive(0, 1, 0, 0, 64'h10, 0, 0, 0, 4'h0); tick();
    drive(0, 1, 1, 1, 64'h11, 1, 0, 0, 4'h0); tick();
    drive(0, 1, 2, 0, 64'h12, 0, 0, 0, 4'h0); tick();
    chk("prerst_state", 64'({ret_vld, ret_tid, slot_busy, err_sticky, err_log_vld}),
        64'({1'b1, 2'd0, 4'b0111, 4'b0010, 1'b1}));
    drive(1, 0, 0, 0, 64'h0, 0, 0, 1, 4'h0); tick();
    chk("rst_ctrl", 64'(ctrl_now()), 64'h0);
    chk("rst_data", ret_data, 64'h0);
    drive(0, 0, 0, 0, 64'h0, 0, 0, 0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("postrst_idle", 64'({ret_vld, slot_busy}), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
